// File: rtl/uart2wifi_pkg.sv
// Shared UART definitions for the uart2wifi core: receiver FSM states and the
// default frame geometry, also intended for the future transmitter.
package uart2wifi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart2wifi_core_uart_rx_if.sv
// Receive-side byte stream: valid/ready byte handshake plus the error pulses.
interface uart2wifi_core_uart_rx_if #(
    parameter int DATA_BITS = uart2wifi_pkg::UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart2wifi_core_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module uart2wifi_core_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart2wifi_core_uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop sampling with a single-entry
// valid/ready output buffer and one-cycle framing/overrun pulses.
module uart2wifi_core_uart_rx
    import uart2wifi_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baudtick,
    input  logic                       rx_in,
    uart2wifi_core_uart_rx_if.master   rx_bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 deliver;
    logic                 rx_s;

    uart2wifi_core_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (baudtick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baudtick) begin
                    if (tick_q == TICK_END) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baudtick) begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The buffer frees up in the same cycle it is drained, so a simultaneous accept is not an overrun.
        if (deliver && (!valid_q || rx_bus.rx_ready)) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (deliver) begin
            ovr_d = 1'b1;
        end else if (valid_q && rx_bus.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_bus.rx_data   = data_q;
    assign rx_bus.rx_valid  = valid_q;
    assign rx_bus.frame_err = ferr_q;
    assign rx_bus.overrun   = ovr_q;

endmodule
